// File: rtl/uart_tx_stream_pkg.sv
// Shared definitions for the uart_tx_stream transmitter: FSM state encoding,
// byte width and the stop-bit / parity-select encodings.
// The PARITY state exists only when UART_TX_STREAM_PARITY_EN is defined.
package uart_pkg;

    localparam int UART_BYTE_BITS = 8;

    // Legal STOP_BITS values
    localparam int UART_STOP_1 = 1;
    localparam int UART_STOP_2 = 2;

    // Legal PARITY_ODD values
    localparam int UART_PARITY_EVEN = 0;
    localparam int UART_PARITY_ODD  = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_STREAM_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_stream_if.sv
// Write-side port of uart_tx_stream: word, write strobe, FIFO space and fill level.
// master = bus-side producer, slave = the transmitter.
interface uart_tx_stream_if #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
);
    logic [DATA_WIDTH-1:0]         data_in;
    logic                          wr_en;
    logic                          wr_ready;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;

    modport master (
        output data_in,
        output wr_en,
        input  wr_ready,
        input  fifo_count
    );

    modport slave (
        input  data_in,
        input  wr_en,
        output wr_ready,
        output fifo_count
    );
endinterface

// File: rtl/uart_tx_stream_fifo.sv
// Synchronous word FIFO for uart_tx_stream. Count, full and empty are all
// registered. A write into an empty FIFO becomes visible on the read side one
// edge after the count updates, so the word is read a full cycle after it lands.
module uart_tx_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_nx;
    logic             full_q, avail_q;
    logic             push_ok, pop_ok;

    // Writes are dropped when full, regardless of a same-cycle pop
    always_comb begin
        push_ok  = push && !full_q;
        pop_ok   = pop && avail_q;
        count_nx = count_q;
        if (push_ok && !pop_ok)
            count_nx = count_q + CNT_ONE;
        else if (!push_ok && pop_ok)
            count_nx = count_q - CNT_ONE;
    end

    // Pointer, count and flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            avail_q  <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop_ok)
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            count_q <= count_nx;
            full_q  <= (count_nx == CNT_FULL);
            // Only goes high once a word has been held for a full cycle
            avail_q <= (count_nx != '0) && (count_q != '0);
        end
    end

    // Storage array, not reset
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr_q] <= din;
    end

    assign dout  = mem[rd_ptr_q];
    assign full  = full_q;
    assign empty = !avail_q;
    assign count = count_q;

endmodule

// File: rtl/uart_tx_stream.sv
// Multi-byte UART transmitter: words from a FIFO are sent as LSB-first byte
// frames (start, 8 data, optional parity, STOP_BITS stop), low byte first.
// Bit timing follows the one-cycle clken baud tick.
// Optional parity bit: define UART_TX_STREAM_PARITY_EN.
module uart_tx_stream
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic            clk,
    input  logic            rst,
    uart_tx_stream_if.slave wr,
    input  logic            clken,
    output logic            tx,
    output logic            tx_busy
);
    localparam int BYTES = DATA_WIDTH / UART_BYTE_BITS;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [IDX_W-1:0] LAST_BYTE = IDX_W'(BYTES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic [2:0]       LAST_BIT  = 3'(UART_BYTE_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    if (DATA_WIDTH < UART_BYTE_BITS || (DATA_WIDTH % UART_BYTE_BITS) != 0) begin : g_bad_width
        $error("uart_tx_stream: DATA_WIDTH must be a non-zero multiple of 8");
    end
    if (STOP_BITS != UART_STOP_1 && STOP_BITS != UART_STOP_2) begin : g_bad_stop
        $error("uart_tx_stream: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD != UART_PARITY_EVEN && PARITY_ODD != UART_PARITY_ODD) begin : g_bad_parity
        $error("uart_tx_stream: PARITY_ODD must be 0 or 1");
    end

    uart_tx_state_t         state_q, state_nx;
    logic [DATA_WIDTH-1:0]  shreg_q;
    logic [DATA_WIDTH-1:0]  fifo_dout;
    logic [IDX_W-1:0]       byte_idx_q;
    logic [2:0]             bit_cnt_q;
    logic                   stop_cnt_q;
    logic                   tx_q;
    logic                   pop;
    logic                   fifo_empty, fifo_full;
    logic [CNT_W-1:0]       fifo_cnt;
    logic                   last_bit, last_stop, last_byte;
`ifdef UART_TX_STREAM_PARITY_EN
    logic                   par_q;
`endif

    uart_tx_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr.wr_en),
        .din   (wr.data_in),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    assign wr.wr_ready   = !fifo_full;
    assign wr.fifo_count = fifo_cnt;

    assign last_bit  = (bit_cnt_q == LAST_BIT);
    assign last_stop = (stop_cnt_q == STOP_LAST);
    assign last_byte = (byte_idx_q == LAST_BYTE);

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_nx;
    end

    // Next-state logic; everything except the IDLE pop waits for a baud tick
    always_comb begin
        state_nx = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty)
                    state_nx = ST_START;
            end
            ST_START: begin
                if (clken)
                    state_nx = ST_DATA;
            end
            ST_DATA: begin
                if (clken && last_bit) begin
`ifdef UART_TX_STREAM_PARITY_EN
                    state_nx = ST_PARITY;
`else
                    state_nx = ST_STOP;
`endif
                end
            end
`ifdef UART_TX_STREAM_PARITY_EN
            ST_PARITY: begin
                if (clken)
                    state_nx = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (clken && last_stop)
                    state_nx = last_byte ? ST_IDLE : ST_START;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // FSM outputs: FIFO pop in IDLE and the busy flag
    always_comb begin
        pop     = (state_q == ST_IDLE) && !fifo_empty;
        tx_busy = (state_q != ST_IDLE);
    end

    // Serial line, bit/byte/stop counters and parity accumulator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_q       <= 1'b1;
            byte_idx_q <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
`ifdef UART_TX_STREAM_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tx_q <= 1'b1;
                    if (pop)
                        byte_idx_q <= '0;
                end
                ST_START: begin
                    if (clken) begin
                        tx_q       <= 1'b0;
                        bit_cnt_q  <= '0;
                        stop_cnt_q <= 1'b0;
`ifdef UART_TX_STREAM_PARITY_EN
                        par_q      <= 1'(PARITY_ODD);
`endif
                    end
                end
                ST_DATA: begin
                    if (clken) begin
                        tx_q      <= shreg_q[0];
                        bit_cnt_q <= bit_cnt_q + 3'd1;
`ifdef UART_TX_STREAM_PARITY_EN
                        par_q     <= par_q ^ shreg_q[0];
`endif
                    end
                end
`ifdef UART_TX_STREAM_PARITY_EN
                ST_PARITY: begin
                    if (clken)
                        tx_q <= par_q;
                end
`endif
                ST_STOP: begin
                    if (clken) begin
                        tx_q       <= 1'b1;
                        stop_cnt_q <= ~stop_cnt_q;
                        if (last_stop && !last_byte)
                            byte_idx_q <= byte_idx_q + IDX_ONE;
                    end
                end
                default: tx_q <= 1'b1;
            endcase
        end
    end

    // Word shift register: loaded on pop, shifted right once per data bit so
    // the next byte lands in the low bits after each frame
    always_ff @(posedge clk) begin
        if (pop)
            shreg_q <= fifo_dout;
        else if (state_q == ST_DATA && clken)
            shreg_q <= shreg_q >> 1;
    end

    assign tx = tx_q;

endmodule

// File: doc/uart_tx_stream.md
# uart_tx_stream

Parametrised multi-byte UART transmitter with an input word FIFO and optional parity. It accepts DATA_WIDTH-bit words from the bus-side logic through a valid/ready-style write port. Each word is serialised as a sequence of standard 8N1/8N2 (or 8E/8O with parity) byte frames, least-significant byte first. Bit timing comes from an external one-cycle baud enable (`clken`) shared with the rest of the serial subsystem.

## Interface
- `DATA_WIDTH`, 16: word width; must be a multiple of 8; BYTES = DATA_WIDTH/8 frames per word.
- `FIFO_DEPTH`, 4: input FIFO depth in words; must be a power of two, ≥2.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.
- `PARITY_ODD`, 0: 0 = even parity, 1 = odd parity; used only when parity is compiled in.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `data_in`  in  DATA_WIDTH  word to transmit.
- `wr_en`  in  1  write strobe; the word is accepted on a `clk` edge when `wr_en && wr_ready`.
- `wr_ready`  out  1  FIFO not full.
- `clken`  in  1  baud tick, one `clk` wide; every serial bit lasts exactly one `clken` period.
- `tx`  out  1  serial line; idles high.
- `tx_busy`  out  1  high whenever the FSM is not in IDLE.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  number of words queued, excluding the word in flight.

## Operation
- Reset values: `tx`=1, `tx_busy`=0, `wr_ready`=1, `fifo_count`=0. The FSM is in IDLE and the FIFO is empty.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - `tx` is held at 1.
  - If the FIFO is non-empty, pop one word into the shift register, clear the byte index and go to START.
  - This step does not wait for `clken`.
- START: on `clken`, drive `tx`=0, clear the bit counter and go to DATA.
- DATA:
  - On each `clken`, drive `tx` = current byte[bit], LSB first.
  - After bit 7, go to PARITY if it is compiled in; otherwise go to STOP.
- PARITY: on `clken`, drive `tx` = XOR of the 8 data bits, XOR `PARITY_ODD`; then go to STOP.
- STOP:
  - On each `clken`, drive `tx`=1 and count stop bits.
  - After `STOP_BITS` ticks: if the byte index < BYTES-1, increment it and go to START; otherwise go to IDLE.
- Byte order: byte k is `data_in[8k+7:8k]`, with k = 0 sent first.
- FIFO rules:
  - A write when full is ignored, even if a pop occurs in the same cycle.
  - A simultaneous write and pop on a non-full FIFO leaves `fifo_count` unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
- `fifo_count` and `wr_ready` are registered, consistent with the FIFO state after each edge.
- When `clken` is held low, the FSM freezes and `tx` holds its value. FIFO writes still proceed.

## Timing
- Each `tx` transition occurs on the `clk` edge where `clken`=1, in START, DATA, PARITY or STOP.
- Latency from write into an empty idle block:
  - The word is popped on the 2nd `clk` edge after acceptance.
  - The start bit begins on the first `clken` after that.
- The last stop bit lasts at least one full `clken` period before the next start bit, whether between bytes or between words.
- Frame length per byte: 1 + 8 + P + STOP_BITS `clken` periods, where P=1 with parity and P=0 without.
- Reset asserted mid-frame: `tx` goes to 1 asynchronously and all FIFO contents are discarded. After release, no partial frame resumes.

## Configuration
- Macro: `UART_TX_STREAM_PARITY_EN`.
- Defined: the PARITY state is present, and one parity bit per byte follows the data bits, as selected by `PARITY_ODD`.
- Undefined: the PARITY state and its logic are absent, DATA goes straight to STOP, and `PARITY_ODD` is ignored.

## Structure
- Shared package `uart_pkg`:
  - the FSM state enum (`uart_tx_state_t`)
  - `UART_BYTE_BITS` = 8
  - the stop-bit and parity-select encodings
- One sub-module, `uart_tx_fifo`: a synchronous FIFO parametrised on width and depth. It provides push, pop, full, empty and count, and resets asynchronously on `rst`.
- The top level holds the FSM, the shift register, the byte and bit counters, and the parity accumulator.

## Test plan
- DATA_WIDTH=16, STOP_BITS=1, no parity, `clken` every 4 clk; write 16'hA55A. Required `tx` per `clken` period:
  - byte 0x5A: 0, 0 1 0 1 1 0 1 0, 1
  - byte 0xA5: 0, 1 0 1 0 0 1 0 1, 1
  - `tx_busy` falls after the last stop bit.
- Parity built, PARITY_ODD=0, write 8'h5A with DATA_WIDTH=8 → parity bit 0. With PARITY_ODD=1 → parity bit 1.
- FIFO_DEPTH=4, `clken` held low, 5 back-to-back writes:
  - the first word is popped into the shift register;
  - words 2–5 fill the FIFO: `wr_ready`=0 and `fifo_count`=4;
  - a 6th write is ignored.
  - Release `clken` and all 5 words are sent in order.
- STOP_BITS=2, two words queued → exactly 2 high periods between consecutive frames, with no idle gap beyond them.
- Assert `rst` in DATA state of byte 1 → `tx`=1 immediately, `fifo_count`=0, `tx_busy`=0. After release, a new write is sent from byte 0.
- `clken` held low for 50 clk in the middle of DATA → `tx` frozen. The bit sequence then resumes uncorrupted.
